mem_master: RTL and testbench
=============================

// Module: mem_master
// PURPOSE
//  Bus initiator for mainMemory. Accepts single read/write, block copy and block fill
//  commands from the CPU/control path, then drives memory address/data/memRead/memWrite.
//  Sits between the control unit and mainMemory, replacing direct CPU strobes.
//  One command in flight; the req/done handshake frees the CPU from memory timing.
// PARAMETERS
//  ADDR_W        8  address width; also the width of len
//  DATA_W        8  data word width
//  READ_LATENCY  1  cycles memRead+address are held before memDataIn is sampled (>=1)
// PORTS
//  clk         in   1       clock, all state on posedge
//  reset       in   1       asynchronous, ACTIVE-LOW reset
//  req         in   1       command strobe; sampled on posedge only while busy=0
//  op          in   2       00 READ, 01 WRITE, 10 COPY, 11 FILL
//  addrA       in   ADDR_W  READ addr / COPY source
//  addrB       in   ADDR_W  WRITE addr / COPY,FILL dest
//  len         in   ADDR_W  word count for COPY/FILL (0 = no memory access)
//  wdata       in   DATA_W  WRITE data / FILL value
//  busy        out  1       command accepted, not yet finished
//  done        out  1       one-cycle completion pulse
//  rdata       out  DATA_W  READ result; held until next accepted command
//  memAddress  out  ADDR_W  to mainMemory address
//  memDataOut  out  DATA_W  to mainMemory dataIn
//  memDataIn   in   DATA_W  from mainMemory dataOut
//  memRead     out  1       to mainMemory memRead
//  memWrite    out  1       to mainMemory memWrite (memory writes on posedge)
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; busy,done,memRead,memWrite=0; rdata,memAddress,
//   memDataOut, internal regs=0. Takes effect immediately, even mid-command; the
//   command is abandoned and memWrite drops without waiting for a clock.
//  States: IDLE, RD, WR, DONE. busy=1 in RD,WR; done=1 only in DONE; memRead=1 only in
//   RD; memWrite=1 only in WR.
//  IDLE: posedge with req=1 latches op,addrA,addrB,len,wdata.
//   READ/COPY -> RD; WRITE/FILL -> WR; COPY/FILL with len=0 -> DONE directly.
//  RD: memAddress=src; hold READ_LATENCY cycles. Last cycle's posedge captures memDataIn
//   into data reg (READ also into rdata). READ -> DONE; COPY -> WR.
//  WR: one cycle, memAddress=dst, memDataOut=data reg (FILL/WRITE: wdata). On exit,
//   src++/dst++ mod 2^ADDR_W, remaining--. WRITE or remaining=0 -> DONE;
//   else COPY -> RD, FILL -> WR.
//  DONE: one cycle, then IDLE. req during RD/WR/DONE is ignored, not queued.
//  Latency at READ_LATENCY=1, from accepting edge T:
//   READ: done high cycle T+2. WRITE: done high T+2. COPY of n words: done at T+2n+1.
//   FILL of n words: done at T+n+1.
//  Address wrap: 0xFF+1 -> 0x00, operation continues; no error flag.
//  COPY is strictly ascending, one word per RD/WR pair. Overlapping src<dst ranges
//   propagate data; this is the defined behaviour.
//  memAddress/memDataOut hold last value in IDLE/DONE; no bus access with strobes low.
// TESTING
//  1 WRITE addrB=0 wdata=196, then READ addrA=0 -> memWrite one cycle at addr 0;
//    rdata=196, done pulse 2 cycles after each accept.
//  2 Preload 0x10..0x12=11,22,33; COPY A=0x10 B=0x20 len=3 -> 0x20..0x22=11,22,33;
//    done at T+7; exactly 3 memWrite cycles.
//  3 FILL B=0xFE len=3 wdata=0xAA -> 0xFE,0xFF,0x00=0xAA (wrap); 0x01 untouched.
//  4 COPY/FILL len=0 -> no memRead/memWrite; done at T+1; busy low throughout.
//  5 req held high with different operands during a COPY -> ignored; only the first
//    command executes; next command accepted only after return to IDLE.
//  6 reset=0 asynchronously mid-COPY during WR -> memWrite and busy fall before the next
//    edge; after release, READ of the partial destination shows only completed words.

Source files
------------

// File: rtl/mem_master_if.sv
// Command and memory bus bundle between the control path, mem_master and mainMemory.
interface mem_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // command side
  logic              req;
  logic [1:0]        op;
  logic [ADDR_W-1:0] addrA;
  logic [ADDR_W-1:0] addrB;
  logic [ADDR_W-1:0] len;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  // memory side
  logic [ADDR_W-1:0] memAddress;
  logic [DATA_W-1:0] memDataOut;
  logic [DATA_W-1:0] memDataIn;
  logic              memRead;
  logic              memWrite;

  // bus initiator view
  modport master (
    input  req, op, addrA, addrB, len, wdata, memDataIn,
    output busy, done, rdata, memAddress, memDataOut, memRead, memWrite
  );

  // control path plus memory view
  modport slave (
    output req, op, addrA, addrB, len, wdata, memDataIn,
    input  busy, done, rdata, memAddress, memDataOut, memRead, memWrite
  );
endinterface

// File: rtl/mem_master.sv
// Bus initiator for mainMemory: single READ/WRITE plus block COPY and FILL.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | waiting for req; operands latched on the accepting edge
//  RD     | memRead + source address held for READ_LATENCY cycles
//  WR     | one memWrite cycle at destination; pointers advance on exit
//  DONE   | one-cycle completion pulse, then back to IDLE
module mem_master #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic           clk,
  input  logic           reset,
  mem_master_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  localparam int              LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0] dout_hold_q, dout_hold_d;

  logic              accept;
  logic              lat_expired;
  logic              last_word;
  logic              busy_o;
  logic              done_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_dout_o;

  assign accept      = (state_q == S_IDLE) && bus.req;
  assign lat_expired = (lat_q == '0);
  // remaining count still includes the word being written this cycle
  assign last_word   = (rem_q == ADDR_W'(1));

  // state register; reset abandons any command in flight immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          case (bus.op)
            OP_READ:  state_d = S_RD;
            OP_WRITE: state_d = S_WR;
            OP_COPY:  state_d = (bus.len == '0) ? S_DONE : S_RD;
            OP_FILL:  state_d = (bus.len == '0) ? S_DONE : S_WR;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_RD: begin
        if (lat_expired) begin
          state_d = (op_q == OP_READ) ? S_DONE : S_WR;
        end
      end
      S_WR: begin
        if ((op_q == OP_WRITE) || last_word) begin
          state_d = S_DONE;
        end else if (op_q == OP_COPY) begin
          state_d = S_RD;
        end else begin
          state_d = S_WR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // bus strobes and address/data muxing; address and data hold their last value when idle
  always_comb begin
    busy_o      = 1'b0;
    done_o      = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = addr_hold_q;
    mem_dout_o  = dout_hold_q;
    case (state_q)
      S_RD: begin
        busy_o     = 1'b1;
        mem_read_o = 1'b1;
        mem_addr_o = src_q;
      end
      S_WR: begin
        busy_o      = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o  = dst_q;
        mem_dout_o  = (op_q == OP_COPY) ? data_q : wdata_q;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  // operand latching, read-latency down-counter, pointer and count updates
  always_comb begin
    op_d        = op_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    data_d      = data_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    lat_d       = lat_q;
    addr_hold_d = mem_addr_o;
    dout_hold_d = mem_dout_o;
    if (accept) begin
      op_d    = bus.op;
      src_d   = bus.addrA;
      dst_d   = bus.addrB;
      rem_d   = bus.len;
      wdata_d = bus.wdata;
      lat_d   = LAT_LOAD;
    end
    case (state_q)
      S_RD: begin
        if (lat_expired) begin
          data_d = bus.memDataIn;
          if (op_q == OP_READ) begin
            rdata_d = bus.memDataIn;
          end
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_WR: begin
        // pointers wrap naturally at 2^ADDR_W; counter is reloaded for the next RD
        src_d = src_q + ADDR_W'(1);
        dst_d = dst_q + ADDR_W'(1);
        rem_d = rem_q - ADDR_W'(1);
        lat_d = LAT_LOAD;
      end
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q        <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      data_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      lat_q       <= '0;
      addr_hold_q <= '0;
      dout_hold_q <= '0;
    end else begin
      op_q        <= op_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      data_q      <= data_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      lat_q       <= lat_d;
      addr_hold_q <= addr_hold_d;
      dout_hold_q <= dout_hold_d;
    end
  end

  assign bus.busy       = busy_o;
  assign bus.done       = done_o;
  assign bus.rdata      = rdata_q;
  assign bus.memRead    = mem_read_o;
  assign bus.memWrite   = mem_write_o;
  assign bus.memAddress = mem_addr_o;
  assign bus.memDataOut = mem_dout_o;

endmodule

// File: tb/tb_mem_master.sv
// Self-checking bench for mem_master: directed table, hand sequences, random commands.
module tb_mem_master;

  localparam int RL    = 1;
  localparam int LIMIT = 1000;

  logic clk;
  logic reset;

  mem_master_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_master #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(RL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural mainMemory: combinational read, write on posedge
  logic [7:0] mem [256];
  assign bus.memDataIn = mem[bus.memAddress];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    forever begin
      @(posedge clk);
      if (bus.memWrite) mem[bus.memAddress] <= bus.memDataOut;
    end
  end

  // reference model state
  logic [7:0] ref_mem [256];
  logic [7:0] ref_rdata;

  int n_pass;
  int n_total;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] len;
    logic [7:0] wd;
    int         lat;
    int         nwr;
    int         nrd;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // command effect from the architectural rules: ascending word-by-word copy, wrap mod 256
  task automatic apply_model(input logic [1:0] op, input logic [7:0] a, b, len, wd);
    logic [7:0] ia, ib;
    case (op)
      2'd0: ref_rdata = ref_mem[a];
      2'd1: ref_mem[b] = wd;
      2'd2: for (int i = 0; i < int'(len); i++) begin
              ia = a + 8'(i);
              ib = b + 8'(i);
              ref_mem[ib] = ref_mem[ia];
            end
      default: for (int i = 0; i < int'(len); i++) begin
              ib = b + 8'(i);
              ref_mem[ib] = wd;
            end
    endcase
  endtask

  function automatic int model_lat(input logic [1:0] op, input logic [7:0] len);
    case (op)
      2'd0:    return RL + 1;
      2'd1:    return 2;
      2'd2:    return (len == 0) ? 1 : int'(len) * (RL + 1) + 1;
      default: return int'(len) + 1;
    endcase
  endfunction

  function automatic int model_wr(input logic [1:0] op, input logic [7:0] len);
    if (op == 2'd0) return 0;
    if (op == 2'd1) return 1;
    return int'(len);
  endfunction

  function automatic int model_rd(input logic [1:0] op, input logic [7:0] len);
    if (op == 2'd0) return RL;
    if (op == 2'd2) return int'(len) * RL;
    return 0;
  endfunction

  // issue a command at a negedge; lat = index of the post-accept cycle showing done
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, b, len, wd,
                         output int lat, output int nwr, output int nrd, output int busy_hi);
    bus.op = op; bus.addrA = a; bus.addrB = b; bus.len = len; bus.wdata = wd;
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    lat = 0; nwr = 0; nrd = 0; busy_hi = 0;
    for (int c = 1; c <= LIMIT; c++) begin
      if (bus.memWrite) nwr++;
      if (bus.memRead) nrd++;
      if (bus.busy) busy_hi = 1;
      if (bus.done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [7:0] a, b, len, wd,
                        input int elat, enwr, enrd);
    int lat, nwr, nrd, bh;
    run_cmd(op, a, b, len, wd, lat, nwr, nrd, bh);
    apply_model(op, a, b, len, wd);
    check({tag, "_latency"}, lat, elat);
    check({tag, "_writes"}, nwr, enwr);
    check({tag, "_reads"}, nrd, enrd);
    check({tag, "_busy_seen"}, bh, (elat > 1) ? 1 : 0);
    check({tag, "_rdata"}, int'(bus.rdata), int'(ref_rdata));
    check({tag, "_mem_diffs"}, mem_diff(), 0);
  endtask

  initial begin
    int c, nwr, lat;
    logic [1:0] rop;
    logic [7:0] ra, rb, rlen, rwd;

    n_pass = 0;
    n_total = 0;
    vecs[0]  = '{2'd1, 8'h00, 8'h00, 8'd0, 8'd196, 2, 1, 0};
    vecs[1]  = '{2'd0, 8'h00, 8'h00, 8'd0, 8'd0,   2, 0, 1};
    vecs[2]  = '{2'd1, 8'h00, 8'h10, 8'd0, 8'd11,  2, 1, 0};
    vecs[3]  = '{2'd1, 8'h00, 8'h11, 8'd0, 8'd22,  2, 1, 0};
    vecs[4]  = '{2'd1, 8'h00, 8'h12, 8'd0, 8'd33,  2, 1, 0};
    vecs[5]  = '{2'd2, 8'h10, 8'h20, 8'd3, 8'd0,   7, 3, 3};
    vecs[6]  = '{2'd3, 8'h00, 8'hFE, 8'd3, 8'hAA,  4, 3, 0};
    vecs[7]  = '{2'd0, 8'h21, 8'h00, 8'd0, 8'd0,   2, 0, 1};
    vecs[8]  = '{2'd2, 8'h30, 8'h31, 8'd0, 8'd0,   1, 0, 0};
    vecs[9]  = '{2'd3, 8'h00, 8'h40, 8'd0, 8'h55,  1, 0, 0};
    vecs[10] = '{2'd0, 8'hFF, 8'h00, 8'd0, 8'd0,   2, 0, 1};
    vecs[11] = '{2'd2, 8'h60, 8'h61, 8'd4, 8'd0,   9, 4, 4};

    bus.req = 1'b0; bus.op = '0; bus.addrA = '0; bus.addrB = '0; bus.len = '0; bus.wdata = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_memRead", int'(bus.memRead), 0);
    check("rst_memWrite", int'(bus.memWrite), 0);
    check("rst_rdata", int'(bus.rdata), 0);
    check("rst_memAddress", int'(bus.memAddress), 0);
    check("rst_memDataOut", int'(bus.memDataOut), 0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    ref_rdata = 8'h00;

    // directed table
    for (int i = 0; i < 12; i++) begin
      do_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].len, vecs[i].wd,
             vecs[i].lat, vecs[i].nwr, vecs[i].nrd);
    end
    check("copy_dst20", int'(mem[8'h20]), 11);
    check("copy_dst21", int'(mem[8'h21]), 22);
    check("copy_dst22", int'(mem[8'h22]), 33);
    check("fill_FE", int'(mem[8'hFE]), 8'hAA);
    check("fill_FF", int'(mem[8'hFF]), 8'hAA);
    check("fill_wrap_00", int'(mem[8'h00]), 8'hAA);

    // req held high with changing operands during a COPY
    bus.op = 2'd2; bus.addrA = 8'h50; bus.addrB = 8'h70; bus.len = 8'd2; bus.wdata = 8'h00;
    bus.req = 1'b1;
    @(negedge clk);
    bus.op = 2'd1; bus.addrA = 8'h00; bus.addrB = 8'h71; bus.len = 8'd9; bus.wdata = 8'h5A;
    lat = 0; nwr = 0;
    for (c = 1; c <= LIMIT; c++) begin
      if (bus.memWrite) nwr++;
      if (bus.done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    check("held_req_copy_latency", lat, 5);
    check("held_req_copy_writes", nwr, 2);
    @(negedge clk);
    check("held_req_ignored_in_done", int'(bus.busy), 0);
    @(negedge clk);
    check("held_req_accepted_in_idle", int'(bus.busy), 1);
    bus.req = 1'b0;
    lat = 0;
    for (c = 1; c <= LIMIT; c++) begin
      if (bus.done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    check("held_req_write_latency", lat, 2);
    @(negedge clk);
    apply_model(2'd2, 8'h50, 8'h70, 8'd2, 8'h00);
    apply_model(2'd1, 8'h00, 8'h71, 8'd0, 8'h5A);
    check("held_req_mem_diffs", mem_diff(), 0);

    // asynchronous reset during the second WR of a COPY
    bus.op = 2'd2; bus.addrA = 8'h40; bus.addrB = 8'h80; bus.len = 8'd4; bus.wdata = 8'h00;
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    nwr = 0;
    for (c = 1; c <= 50; c++) begin
      if (bus.memWrite) nwr++;
      if (nwr == 2) break;
      @(negedge clk);
    end
    check("abort_reached_second_wr", nwr, 2);
    reset = 1'b0;
    #1;
    check("abort_memWrite_low", int'(bus.memWrite), 0);
    check("abort_busy_low", int'(bus.busy), 0);
    check("abort_memRead_low", int'(bus.memRead), 0);
    check("abort_memAddress", int'(bus.memAddress), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    apply_model(2'd2, 8'h40, 8'h80, 8'd1, 8'h00);
    ref_rdata = 8'h00;
    check("abort_rdata_cleared", int'(bus.rdata), 0);
    check("abort_mem_diffs", mem_diff(), 0);
    do_cmd("abort_rd80", 2'd0, 8'h80, 8'h00, 8'd0, 8'd0, 2, 0, 1);
    do_cmd("abort_rd81", 2'd0, 8'h81, 8'h00, 8'd0, 8'd0, 2, 0, 1);

    // randomized commands against the reference model
    for (int i = 0; i < 40; i++) begin
      rop  = 2'($urandom_range(0, 3));
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rlen = 8'($urandom_range(0, 12));
      rwd  = 8'($urandom);
      do_cmd($sformatf("rnd%0d", i), rop, ra, rb, rlen, rwd,
             model_lat(rop, rlen), model_wr(rop, rlen), model_rd(rop, rlen));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
